// File: rtl/multi_seg_scan_driver.sv
// multi_seg_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-cathode 7-segment digits on a
// shared segment bus. BCD digits and decimal points are captured into a shadow
// register on 'load'. Digits are scanned round-robin, one slot of SCAN_DIV
// cycles each. digit_sel is held low for the first BLANK_CYCLES of every slot
// so the previous digit's segments never ghost onto the next digit.
// Optional feature: define SEG_BLINK_EN to add the blink_mask port and the
// frame-based blink phase (BLINK_DIV frames per half-period).
module multi_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_DIV    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // BCD to {a,b,c,d,e,f,g}; codes 10-15 are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0]        div_cnt_r;
  logic [IDX_W-1:0]        digit_idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   digit_sel_r;
  logic                    frame_tick_r;

  logic                    slot_end_s;
  logic                    frame_end_s;
  logic                    blank_s;
  logic                    hide_s;
  logic                    seen_nz_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [3:0]              cur_code_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;

  assign slot_end_s  = (div_cnt_r == DIV_W'(SCAN_DIV - 1));
  assign frame_end_s = slot_end_s && (digit_idx_r == IDX_W'(NUM_DIGITS - 1));
  assign blank_s     = (div_cnt_r < DIV_W'(BLANK_CYCLES));

  // Slot prescaler and digit index; the index wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r   <= '0;
      digit_idx_r <= '0;
    end else if (slot_end_s) begin
      div_cnt_r <= '0;
      if (digit_idx_r == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx_r <= '0;
      end else begin
        digit_idx_r <= digit_idx_r + IDX_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Shadow capture of digits and decimal points; independent of the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r    <= '0;
      shadow_dp_r <= '0;
    end else if (load) begin
      shadow_r    <= bcd_in;
      shadow_dp_r <= dp_in;
    end else begin
      shadow_r    <= shadow_r;
      shadow_dp_r <= shadow_dp_r;
    end
  end

  // Leading-zero mask: walk down from the top digit until a non-zero code.
  // Codes 10-15 count as non-zero; digit 0 is always shown.
  always_comb begin
    seen_nz_s = 1'b0;
    lz_mask_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz_s    = seen_nz_s | (shadow_r[4*i +: 4] != 4'd0);
      lz_mask_s[i] = lz_blank & ~seen_nz_s & (i != 0);
    end
  end

  // Select the current digit's code, dp, blank flag and one-hot enable.
  always_comb begin
    cur_code_s = 4'd0;
    cur_dp_s   = 1'b0;
    cur_lz_s   = 1'b0;
    onehot_s   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_r == IDX_W'(i)) begin
        cur_code_s  = shadow_r[4*i +: 4];
        cur_dp_s    = shadow_dp_r[i];
        cur_lz_s    = lz_mask_s[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FC_W-1:0] frame_cnt_r;
  logic            blink_phase_r;

  // Frame counter; blink phase flips after every BLINK_DIV completed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_end_s) begin
      if (frame_cnt_r == FC_W'(BLINK_DIV - 1)) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r   <= frame_cnt_r + FC_W'(1);
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      frame_cnt_r   <= frame_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end

  assign hide_s = blink_phase_r & (|(blink_mask & onehot_s));
`else
  assign hide_s = 1'b0;
`endif

  // Registered display outputs, one cycle behind the scan state.
  // Segments are not gated by the blank interval; only digit_sel is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= 7'b0000000;
      dp_r         <= 1'b0;
      digit_sel_r  <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= frame_end_s;
      if (hide_s) begin
        seg_r       <= 7'b0000000;
        dp_r        <= 1'b0;
        digit_sel_r <= '0;
      end else begin
        seg_r       <= cur_lz_s ? 7'b0000000 : seg_decode(cur_code_s);
        dp_r        <= cur_dp_s;
        digit_sel_r <= blank_s ? '0 : onehot_s;
      end
    end
  end

  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign digit_sel  = digit_sel_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_multi_seg_scan_driver.sv
// Directed bench for multi_seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1, BLINK_DIV=2). Blink checks are compiled with SEG_BLINK_EN.
// edge_n counts rising edges since reset release; outputs after edge n
// reflect scan state n-1: div = (n-1)%4, digit = ((n-1)/4)%4.
module tb_multi_seg_scan_driver;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] bcd_in   = 16'h0000;
  logic [3:0]  dp_in    = 4'b0000;
  logic        lz_blank = 1'b0;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask = 4'b0001;
`endif
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  multi_seg_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1),
    .BLINK_DIV   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .lz_blank  (lz_blank),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto_edge(input int target);
    while (edge_n < target) step();
  endtask

  task automatic do_load(input logic [15:0] bcd, input logic [3:0] dp);
    bcd_in = bcd;
    dp_in  = dp;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Advance to the middle of digit d's slot and check all display outputs.
  task automatic check_slot(input string tag, input int d, input logic [6:0] exp_seg, input logic exp_dp);
    int n;
    logic [3:0] oh;
    n = edge_n + 1;
    while ((((n - 1) % 4) != 2) || ((((n - 1) / 4) % 4) != d)) n++;
    goto_edge(n);
    oh = 4'b0001 << d;
    check_val({tag, "_sel"}, 32'(digit_sel), 32'(oh));
    check_val({tag, "_seg"}, 32'(seg_out), 32'(exp_seg));
    check_val({tag, "_dp"}, 32'(dp_out), 32'(exp_dp));
  endtask

  logic [3:0] sel_tbl [9];
  int n_ft;

  initial begin
    sel_tbl = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_seg", 32'(seg_out), 32'd0);
    check_val("rst_dp", 32'(dp_out), 32'd0);
    check_val("rst_sel", 32'(digit_sel), 32'd0);
    check_val("rst_ft", 32'(frame_tick), 32'd0);

    // Scan order after release
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      check_val($sformatf("scan_sel_e%0d", i + 1), 32'(digit_sel), 32'(sel_tbl[i]));
    end

    // frame_tick once per 16 edges
    goto_edge(15);
    check_val("ft_e15", 32'(frame_tick), 32'd0);
    step();
    check_val("ft_e16", 32'(frame_tick), 32'd1);
    step();
    check_val("ft_e17", 32'(frame_tick), 32'd0);
    n_ft = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (frame_tick === 1'b1) n_ft++;
    end
    check_val("ft_e32", 32'(frame_tick), 32'd1);
    check_val("ft_count_e18_32", 32'(n_ft), 32'd1);

    // Decode
    do_load(16'h1234, 4'b0000);
    check_slot("dec1234_d0", 0, 7'b0110011, 1'b0);
    check_slot("dec1234_d1", 1, 7'b1111001, 1'b0);
    check_slot("dec1234_d2", 2, 7'b1101101, 1'b0);
    check_slot("dec1234_d3", 3, 7'b0110000, 1'b0);
    do_load(16'hABCF, 4'b0000);
    check_slot("decABCF_d0", 0, 7'b0000000, 1'b0);
    check_slot("decABCF_d1", 1, 7'b0000000, 1'b0);
    check_slot("decABCF_d2", 2, 7'b0000000, 1'b0);
    check_slot("decABCF_d3", 3, 7'b0000000, 1'b0);

    // Leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b1000);
    check_slot("lz0050_d3", 3, 7'b0000000, 1'b1);
    check_slot("lz0050_d2", 2, 7'b0000000, 1'b0);
    check_slot("lz0050_d1", 1, 7'b1011011, 1'b0);
    check_slot("lz0050_d0", 0, 7'b1111110, 1'b0);
    do_load(16'h0000, 4'b0000);
    check_slot("lz0000_d3", 3, 7'b0000000, 1'b0);
    check_slot("lz0000_d2", 2, 7'b0000000, 1'b0);
    check_slot("lz0000_d1", 1, 7'b0000000, 1'b0);
    check_slot("lz0000_d0", 0, 7'b1111110, 1'b0);
    do_load(16'h0A00, 4'b0000);
    check_slot("lz0A00_d3", 3, 7'b0000000, 1'b0);
    check_slot("lz0A00_d1", 1, 7'b1111110, 1'b0);
    do_load(16'h0000, 4'b0000);
    lz_blank = 1'b0;
    check_slot("lzoff_d3", 3, 7'b1111110, 1'b0);

    // Load timing: load mid-slot of digit 1
    check_slot("ldt_pre", 1, 7'b1111110, 1'b0);
    bcd_in = 16'h9999;
    load   = 1'b1;
    step();
    load   = 1'b0;
    check_val("ldt_edge_seg", 32'(seg_out), 32'(7'b1111110));
    check_val("ldt_edge_sel", 32'(digit_sel), 32'(4'b0010));
    step();
    check_val("ldt_next_seg", 32'(seg_out), 32'(7'b1111011));
    check_val("ldt_next_sel", 32'(digit_sel), 32'(4'b0000));
    check_slot("ldt_d2", 2, 7'b1111011, 1'b0);

    // Asynchronous reset mid-scan, while frame_tick is high
    do_load(16'h9999, 4'b1111);
    goto_edge(((edge_n / 16) + 1) * 16);
    check_val("ar_pre_ft", 32'(frame_tick), 32'd1);
    check_val("ar_pre_sel", 32'(digit_sel), 32'(4'b1000));
    check_val("ar_pre_seg", 32'(seg_out), 32'(7'b1111011));
    check_val("ar_pre_dp", 32'(dp_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_seg", 32'(seg_out), 32'd0);
    check_val("ar_dp", 32'(dp_out), 32'd0);
    check_val("ar_sel", 32'(digit_sel), 32'd0);
    check_val("ar_ft", 32'(frame_tick), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("ar_hold_sel", 32'(digit_sel), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    step();
    check_val("ar_rel_e1_sel", 32'(digit_sel), 32'(4'b0000));
    step();
    check_val("ar_rel_e2_sel", 32'(digit_sel), 32'(4'b0001));
    check_val("ar_rel_e2_seg", 32'(seg_out), 32'(7'b1111110));
    check_val("ar_rel_e2_dp", 32'(dp_out), 32'd0);

`ifdef SEG_BLINK_EN
    // Blink: digit 0 dark in frames 3-4, digit 1 always visible
    for (int f = 1; f <= 6; f++) begin
      goto_edge(16 * (f - 1) + 3);
      if (f == 3 || f == 4) begin
        check_val($sformatf("blink_f%0d_d0_sel", f), 32'(digit_sel), 32'd0);
        check_val($sformatf("blink_f%0d_d0_seg", f), 32'(seg_out), 32'd0);
      end else begin
        check_val($sformatf("blink_f%0d_d0_sel", f), 32'(digit_sel), 32'(4'b0001));
        check_val($sformatf("blink_f%0d_d0_seg", f), 32'(seg_out), 32'(7'b1111110));
      end
      goto_edge(16 * (f - 1) + 7);
      check_val($sformatf("blink_f%0d_d1_sel", f), 32'(digit_sel), 32'(4'b0010));
      check_val($sformatf("blink_f%0d_d1_seg", f), 32'(seg_out), 32'(7'b1111110));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
